phase_meter: RTL and testbench



---
 rtl/phase_meter.sv | 199 +++++++++++++++++++
 tb/tb_phase_meter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/phase_meter.sv
// Phase meter: counts fclk cycles from a reference rise to a signal rise and
// offers each result through a one-entry valid/ready slot. PHASE_METER_AVG_EN averages groups of 4.
module phase_meter #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             fclk,
  input  logic             rstb,
  input  logic             enable,
  input  logic             ref_in,
  input  logic             sig_in,
  output logic [CNT_W-1:0] phase_cnt,
  output logic             phase_valid,
  input  logic             phase_ready,
  output logic             miss,
  output logic             overrun,
  output logic             sat
);

  typedef enum logic [1:0] {IDLE, ARM, COUNT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] ref_sync_q, sig_sync_q;
  logic                   ref_dly_q, sig_dly_q;
  logic                   rise_ref, rise_sig;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             emit_q, emit_sat_q, miss_q;
  logic [CNT_W-1:0] emit_cnt_q;

  logic [CNT_W-1:0] slot_cnt_q;
  logic             slot_valid_q, slot_sat_q, overrun_q;

  logic [CNT_W-1:0] cnt_inc;
  logic             inc_sat;
  logic             meas_fire, miss_fire, meas_sat;
  logic [CNT_W-1:0] meas_val;
  logic             drain;

`ifdef PHASE_METER_AVG_EN
  logic [CNT_W+1:0] acc_q;
  logic [1:0]       grp_q;
  logic             sat_acc_q;
`endif

  // Equal-length synchronizer chains on both inputs keep the measured separation exact.
  always_ff @(posedge fclk or negedge rstb) begin
    if (!rstb) begin
      ref_sync_q <= '0;
      sig_sync_q <= '0;
      ref_dly_q  <= 1'b0;
      sig_dly_q  <= 1'b0;
    end else begin
      ref_sync_q <= {ref_sync_q[SYNC_STAGES-2:0], ref_in};
      sig_sync_q <= {sig_sync_q[SYNC_STAGES-2:0], sig_in};
      ref_dly_q  <= ref_sync_q[SYNC_STAGES-1];
      sig_dly_q  <= sig_sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_ref = ref_sync_q[SYNC_STAGES-1] & ~ref_dly_q;
  assign rise_sig = sig_sync_q[SYNC_STAGES-1] & ~sig_dly_q;

  // The reported value includes the increment of the cycle the sig rise is seen.
  assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
  assign inc_sat = (cnt_inc == CNT_MAX);

  always_comb begin
    meas_fire = 1'b0;
    miss_fire = 1'b0;
    meas_val  = cnt_inc;
    meas_sat  = inc_sat;
    if (enable) begin
      case (state_q)
        ARM: begin
          if (rise_ref && rise_sig) begin
            meas_fire = 1'b1;
            meas_val  = '0;
            meas_sat  = 1'b0;
          end
        end
        COUNT: begin
          if (rise_sig)      meas_fire = 1'b1;
          else if (rise_ref) miss_fire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge fclk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      emit_q     <= 1'b0;
      emit_cnt_q <= '0;
      emit_sat_q <= 1'b0;
      miss_q     <= 1'b0;
`ifdef PHASE_METER_AVG_EN
      acc_q      <= '0;
      grp_q      <= '0;
      sat_acc_q  <= 1'b0;
`endif
    end else begin
      miss_q <= miss_fire;
      if (!enable) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            state_q <= ARM;
          end
          ARM: begin
            cnt_q <= '0;
            if (rise_ref) state_q <= rise_sig ? ARM : COUNT;
          end
          COUNT: begin
            if (rise_ref) begin
              cnt_q <= '0;
            end else if (rise_sig) begin
              cnt_q   <= '0;
              state_q <= ARM;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        endcase
      end
`ifdef PHASE_METER_AVG_EN
      emit_q <= 1'b0;
      if (!enable || state_q == IDLE || miss_fire) begin
        acc_q     <= '0;
        grp_q     <= '0;
        sat_acc_q <= 1'b0;
      end else if (meas_fire) begin
        if (grp_q == 2'd3) begin
          emit_q     <= 1'b1;
          emit_cnt_q <= CNT_W'((acc_q + {2'b00, meas_val}) >> 2);
          emit_sat_q <= sat_acc_q | meas_sat;
          acc_q      <= '0;
          grp_q      <= '0;
          sat_acc_q  <= 1'b0;
        end else begin
          acc_q     <= acc_q + {2'b00, meas_val};
          grp_q     <= grp_q + 2'd1;
          sat_acc_q <= sat_acc_q | meas_sat;
        end
      end
`else
      emit_q <= meas_fire;
      if (meas_fire) begin
        emit_cnt_q <= meas_val;
        emit_sat_q <= meas_sat;
      end
`endif
    end
  end

  assign drain = slot_valid_q & phase_ready;

  // A full slot that is not draining keeps its old result and drops the new one.
  always_ff @(posedge fclk or negedge rstb) begin
    if (!rstb) begin
      slot_cnt_q   <= '0;
      slot_valid_q <= 1'b0;
      slot_sat_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (emit_q) begin
        if (!slot_valid_q || drain) begin
          slot_cnt_q   <= emit_cnt_q;
          slot_sat_q   <= emit_sat_q;
          slot_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (drain) begin
        slot_valid_q <= 1'b0;
      end
    end
  end

  assign phase_cnt   = slot_cnt_q;
  assign phase_valid = slot_valid_q;
  assign sat         = slot_sat_q;
  assign miss        = miss_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_phase_meter.sv
// Directed bench for phase_meter (CNT_W=8, SYNC_STAGES=2); PHASE_METER_AVG_EN selects the averaging checks.
module tb_phase_meter;

  logic       fclk = 1'b0;
  logic       rstb = 1'b0;
  logic       enable = 1'b0;
  logic       ref_in = 1'b0;
  logic       sig_in = 1'b0;
  logic       phase_ready = 1'b0;
  logic [7:0] phase_cnt;
  logic       phase_valid, miss, overrun, sat;

  int checks = 0;
  int failures = 0;
  int miss_n = 0, ovr_n = 0, acc_n = 0;
  int last_cnt = -1, last_sat = -1;
  int base_acc, base_miss, base_ovr;

  phase_meter #(.CNT_W(8), .SYNC_STAGES(2)) dut (
    .fclk(fclk), .rstb(rstb), .enable(enable), .ref_in(ref_in), .sig_in(sig_in),
    .phase_cnt(phase_cnt), .phase_valid(phase_valid), .phase_ready(phase_ready),
    .miss(miss), .overrun(overrun), .sat(sat)
  );

  always #5 fclk = ~fclk;

  // Event monitor sampled away from the rising edge.
  always @(negedge fclk) begin
    if (miss) miss_n++;
    if (overrun) ovr_n++;
    if (phase_valid && phase_ready) begin
      acc_n++;
      last_cnt = int'(phase_cnt);
      last_sat = int'(sat);
      $display("accept cnt=%0d sat=%0d t=%0t", phase_cnt, sat, $time);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge fclk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One ref rise followed by a sig rise `delay` cycles later, then settle.
  task automatic measure(input int delay);
    ref_in = 1'b1;
    if (delay > 0) step(delay);
    sig_in = 1'b1;
    step(2);
    ref_in = 1'b0;
    sig_in = 1'b0;
    step(8);
  endtask

  task automatic two_refs_no_sig();
    ref_in = 1'b1; step(3);
    ref_in = 1'b0; step(3);
    ref_in = 1'b1; step(3);
    ref_in = 1'b0; step(5);
  endtask

  task automatic rearm();
    enable = 1'b0; step(2);
    enable = 1'b1; step(3);
  endtask

  initial begin
    step(3);
    check("reset_cnt", int'(phase_cnt), 0);
    check("reset_valid", int'(phase_valid), 0);
    check("reset_miss", int'(miss), 0);
    check("reset_overrun", int'(overrun), 0);
    check("reset_sat", int'(sat), 0);
    rstb = 1'b1;
    phase_ready = 1'b1;
    enable = 1'b1;
    step(3);

`ifndef PHASE_METER_AVG_EN
    // Delay 5 and output latency: valid set by the 4th edge counting the sampling edge.
    ref_in = 1'b1;
    step(5);
    sig_in = 1'b1;
    step(3);
    check("lat_not_yet", int'(phase_valid), 0);
    step(1);
    check("lat_valid", int'(phase_valid), 1);
    check("d5_cnt", int'(phase_cnt), 5);
    check("d5_sat", int'(sat), 0);
    step(1);
    check("d5_drained", int'(phase_valid), 0);
    ref_in = 1'b0; sig_in = 1'b0;
    step(5);
    check("d5_accepts", acc_n, 1);

    measure(0);
    check("same_cycle_cnt", last_cnt, 0);
    check("same_cycle_accepts", acc_n, 2);

    two_refs_no_sig();
    check("miss_count", miss_n, 1);
    check("miss_no_result", acc_n, 2);
    rearm();

    measure(300);
    check("d300_cnt", last_cnt, 255);
    check("d300_sat", last_sat, 1);
    measure(254);
    check("d254_cnt", last_cnt, 254);
    check("d254_sat", last_sat, 0);

    phase_ready = 1'b0;
    base_acc = acc_n; base_ovr = ovr_n;
    measure(3);
    measure(7);
    check("ovr_valid_held", int'(phase_valid), 1);
    check("ovr_cnt_kept", int'(phase_cnt), 3);
    check("ovr_pulses", ovr_n - base_ovr, 1);
    phase_ready = 1'b1;
    step(1);
    check("ovr_drained", int'(phase_valid), 0);
    check("ovr_accept_cnt", last_cnt, 3);
    check("ovr_accepts", acc_n - base_acc, 1);

    base_acc = acc_n; base_miss = miss_n;
    ref_in = 1'b1;
    step(6);
    enable = 1'b0;
    step(2);
    sig_in = 1'b1;
    step(10);
    check("dis_no_emit", acc_n - base_acc, 0);
    check("dis_no_miss", miss_n - base_miss, 0);
    check("dis_valid", int'(phase_valid), 0);
    ref_in = 1'b0; sig_in = 1'b0;
    enable = 1'b1;
    step(4);

    phase_ready = 1'b0;
    measure(4);
    check("pend_valid", int'(phase_valid), 1);
    check("pend_cnt", int'(phase_cnt), 4);
    #2 rstb = 1'b0;
    #1;
    check("rst_async_valid", int'(phase_valid), 0);
    check("rst_async_cnt", int'(phase_cnt), 0);
    step(2);
    rstb = 1'b1;
    step(2);
    check("rst_after_valid", int'(phase_valid), 0);
    check("rst_after_sat", int'(sat), 0);
`else
    base_acc = acc_n;
    measure(4);
    measure(5);
    measure(6);
    check("avg_partial_none", acc_n - base_acc, 0);
    measure(8);
    check("avg_one_result", acc_n - base_acc, 1);
    check("avg_cnt", last_cnt, 5);
    check("avg_sat", last_sat, 0);

    base_acc = acc_n; base_miss = miss_n;
    measure(3);
    measure(3);
    two_refs_no_sig();
    check("avg_miss_pulse", miss_n - base_miss, 1);
    rearm();
    measure(10);
    measure(10);
    check("avg_restart_none", acc_n - base_acc, 0);
    measure(10);
    measure(10);
    check("avg_restart_one", acc_n - base_acc, 1);
    check("avg_restart_cnt", last_cnt, 10);
    check("avg_restart_sat", last_sat, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
